compress_frame_tagger: RTL and testbench



---
 rtl/compress_pkg.sv | 20 ++
 rtl/lane_xor_fold.sv | 16 +
 rtl/compress_frame_tagger.sv | 118 +++++++++++
 tb/tb_compress_frame_tagger.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compress_pkg.sv
// Shared types and trailer layout for the compressor frame tagger.
// The checksum lane fold is built only when TRAILER_CHECKSUM_EN is defined.
package compress_pkg;

  localparam int BURST_WIDTH_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BODY    = 2'd1,
    TRAILER = 2'd2
  } state_t;

  localparam logic [15:0] TRAILER_MARKER = 16'hC0DE;

  // Trailer beat field offsets (LSB positions)
  localparam int CSUM_LSB   = 0;
  localparam int CNT_LSB    = 32;
  localparam int MARKER_LSB = 48;

endpackage

// File: rtl/lane_xor_fold.sv
// Combinational XOR fold of a W-bit word into one 32-bit lane.
module lane_xor_fold #(
  parameter int W = 256
) (
  input  logic [W-1:0] word,
  output logic [31:0]  fold
);

  always_comb begin
    fold = '0;
    for (int i = 0; i < W / 32; i++) begin
      fold = fold ^ word[32*i +: 32];
    end
  end

endmodule

// File: rtl/compress_frame_tagger.sv
// Drains a show-ahead FIFO onto an AXI-stream master and appends a count/checksum
// trailer to compressible packets. TRAILER_CHECKSUM_EN enables the XOR checksum.
//
// Handshake: a beat transfers on a rising clk edge where m_tvalid && m_tready;
// once m_tvalid is high, m_tdata/m_tlast/m_tuser hold until that transfer.
module compress_frame_tagger
  import compress_pkg::*;
#(
  parameter int BURST_WIDTH = BURST_WIDTH_DEF,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BURST_WIDTH-1:0] fifo_data,
  input  logic                   fifo_last,
  input  logic                   fifo_hdr,
  input  logic                   fifo_flag,
  input  logic                   fifo_empty,
  output logic                   pop_fifo,
  output logic [BURST_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   m_tuser,
  output state_t                 dbg_state
);

  state_t                 state, state_n;
  logic                   pkt_flag, flag_eff;
  logic                   load, trailer_go, first;
  logic [CNT_WIDTH-1:0]   count, cnt_base, cnt_acc;
  logic [31:0]            checksum;
  logic [BURST_WIDTH-1:0] trailer_word;

  assign dbg_state = state;

  always_comb begin
    load       = !m_tvalid || m_tready;
    pop_fifo   = !fifo_empty && load && (state != TRAILER);
    trailer_go = load && (state == TRAILER);
    first      = (state == IDLE);
    // The first beat of a packet defines its flag and restarts accumulation
    flag_eff   = first ? fifo_flag : pkt_flag;
    cnt_base   = first ? '0 : count;
    cnt_acc    = cnt_base;
    if (!fifo_hdr && !(&cnt_base)) begin
      cnt_acc = cnt_base + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    state_n = state;
    if (pop_fifo) begin
      if (fifo_last) state_n = flag_eff ? TRAILER : IDLE;
      else           state_n = BODY;
    end else if (trailer_go) begin
      state_n = IDLE;
    end

    trailer_word = '0;
    trailer_word[CSUM_LSB +: 32]   = checksum;
    trailer_word[CNT_LSB +: 16]    = 16'(count);
    trailer_word[MARKER_LSB +: 16] = TRAILER_MARKER;
  end

`ifdef TRAILER_CHECKSUM_EN
  logic [31:0] beat_fold;
  logic [31:0] csum_base, csum_acc;

  lane_xor_fold #(.W(BURST_WIDTH)) u_fold (
    .word (fifo_data),
    .fold (beat_fold)
  );

  always_comb begin
    csum_base = first ? 32'h0 : checksum;
    csum_acc  = fifo_hdr ? csum_base : (csum_base ^ beat_fold);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (pop_fifo) begin
      checksum <= csum_acc;
    end
  end
`else
  assign checksum = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pkt_flag <= 1'b0;
      count    <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else begin
      state <= state_n;
      if (pop_fifo) begin
        pkt_flag <= flag_eff;
        count    <= cnt_acc;
        m_tvalid <= 1'b1;
        m_tdata  <= fifo_data;
        m_tlast  <= fifo_last && !flag_eff;
        m_tuser  <= flag_eff;
      end else if (trailer_go) begin
        m_tvalid <= 1'b1;
        m_tdata  <= trailer_word;
        m_tlast  <= 1'b1;
        m_tuser  <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_compress_frame_tagger.sv
// Scoreboard bench for compress_frame_tagger: a packet-level model fills an
// expected queue, a negedge monitor checks every output handshake.
module tb_compress_frame_tagger;
  import compress_pkg::*;

  localparam int BW = 256;
  localparam int EW = BW + 2;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic          hdr;
    logic          flag;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [BW-1:0] fifo_data = '0;
  logic          fifo_last = 1'b0;
  logic          fifo_hdr = 1'b0;
  logic          fifo_flag = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          pop_fifo;
  logic [BW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          m_tuser;
  state_t        dbg_state;

  compress_frame_tagger #(.BURST_WIDTH(BW), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo_data  (fifo_data),
    .fifo_last  (fifo_last),
    .fifo_hdr   (fifo_hdr),
    .fifo_flag  (fifo_flag),
    .fifo_empty (fifo_empty),
    .pop_fifo   (pop_fifo),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 pattern 1,0,0,1, 3 never
  logic pop_seen = 1'b0;

  ent_t          fifo_q[$];
  ent_t          pkt_q[$];
  logic [EW-1:0] exp_q[$];
  int            hs_q[$];

  logic          held_valid = 1'b0;
  logic [EW-1:0] held_beat;

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_sum(input logic [BW-1:0] d);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < BW / 32; i++) s = s ^ d[i*32 +: 32];
    return s;
  endfunction

  // reference model: whole-packet framing rules
  task automatic add_beat(input logic [BW-1:0] d, input logic hdr, input logic last, input logic flag);
    ent_t e;
    e.data = d; e.hdr = hdr; e.last = last; e.flag = flag;
    pkt_q.push_back(e);
  endtask

  task automatic issue_pkt();
    logic          flag;
    int            cnt;
    logic [31:0]   cs;
    logic [BW-1:0] tr;
    flag = pkt_q[0].flag;
    cnt = 0;
    cs = 32'h0;
    foreach (pkt_q[i]) begin
      exp_q.push_back({pkt_q[i].last && !flag, flag, pkt_q[i].data});
      fifo_q.push_back(pkt_q[i]);
      if (!pkt_q[i].hdr) begin
        if (cnt < 65535) cnt++;
        cs = cs ^ lane_sum(pkt_q[i].data);
      end
    end
    if (flag && pkt_q[pkt_q.size()-1].last) begin
      tr = '0;
      tr[63:48] = 16'hC0DE;
      tr[47:32] = cnt[15:0];
`ifdef TRAILER_CHECKSUM_EN
      tr[31:0] = cs;
`endif
      exp_q.push_back({1'b1, 1'b1, tr});
    end
    pkt_q.delete();
  endtask

  task automatic rand_pkt();
    int   nb;
    logic flag;
    logic [BW-1:0] d;
    nb = $urandom_range(1, 8);
    flag = 1'($urandom_range(0, 1));
    for (int i = 0; i < nb; i++) begin
      for (int l = 0; l < BW / 32; l++) d[l*32 +: 32] = $urandom;
      add_beat(d, ($urandom_range(0, 3) == 0), (i == nb - 1),
               (i == 0) ? flag : 1'($urandom_range(0, 1)));
    end
    issue_pkt();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout with %0d beats outstanding, required 0", name, exp_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  // driver: FIFO model and ready generation
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      #1;
      fifo_empty = (fifo_q.size() == 0);
      if (fifo_q.size() > 0) begin
        fifo_data = fifo_q[0].data;
        fifo_last = fifo_q[0].last;
        fifo_hdr  = fifo_q[0].hdr;
        fifo_flag = fifo_q[0].flag;
      end else begin
        fifo_data = {8{32'($urandom)}};
        fifo_last = 1'($urandom_range(0, 1));
        fifo_hdr  = 1'($urandom_range(0, 1));
        fifo_flag = 1'($urandom_range(0, 1));
      end
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = 1'($urandom_range(0, 1));
        2: m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // monitor
  always @(negedge clk) begin
    pop_seen = pop_fifo;
    if (reset_n) begin
      if (m_tvalid && !m_tready) check("no_pop_in_stall", {{(EW-1){1'b0}}, pop_fifo}, '0);
      if (held_valid) check("stall_hold", {m_tvalid ? m_tlast : 1'bx, m_tuser, m_tdata}, held_beat);
      held_valid = m_tvalid && !m_tready;
      held_beat = {m_tlast, m_tuser, m_tdata};
      if (m_tvalid && m_tready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h required none", {m_tlast, m_tuser, m_tdata});
        end else begin
          check("beat", {m_tlast, m_tuser, m_tdata}, exp_q.pop_front());
        end
      end
    end else begin
      held_valid = 1'b0;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_outputs", {m_tlast, m_tuser, m_tdata}, '0);
    check("reset_valid", {{(EW-2){1'b0}}, m_tvalid, pop_fifo}, '0);
    check("reset_state", EW'(dbg_state), EW'(IDLE));

    // unflagged 6 beats, streaming
    rdy_mode = 0;
    hs_q.delete();
    for (int i = 0; i < 6; i++) add_beat({(BW/32){32'(i + 16)}}, (i < 4), (i == 5), 1'b0);
    issue_pkt();
    wait_drain("unflagged", 200);
    check("stream_beats", EW'(hs_q.size()), EW'(6));
    if (hs_q.size() == 6) check("stream_rate", EW'(hs_q[5] - hs_q[0]), EW'(5));

    // flagged, identical lanes: checksum 0, count 3
    for (int i = 0; i < 4; i++) add_beat({(BW/32){32'hA0 + 32'(i)}}, 1'b1, 1'b0, 1'b1);
    add_beat({(BW/32){32'h1}}, 1'b0, 1'b0, 1'b0);
    add_beat({(BW/32){32'h2}}, 1'b0, 1'b0, 1'b1);
    add_beat({(BW/32){32'h4}}, 1'b0, 1'b1, 1'b0);
    issue_pkt();
    wait_drain("flagged_lanes", 200);

    // flagged, lane0 only: checksum 7
    for (int i = 0; i < 4; i++) add_beat({(BW/32){32'hB0 + 32'(i)}}, 1'b1, 1'b0, 1'b1);
    add_beat({{(BW-32){1'b0}}, 32'h1}, 1'b0, 1'b0, 1'b1);
    add_beat({{(BW-32){1'b0}}, 32'h2}, 1'b0, 1'b0, 1'b1);
    add_beat({{(BW-32){1'b0}}, 32'h4}, 1'b0, 1'b1, 1'b1);
    issue_pkt();
    wait_drain("flagged_lane0", 200);

    // backpressure pattern
    rdy_mode = 2;
    add_beat({(BW/32){32'hC1}}, 1'b1, 1'b0, 1'b1);
    add_beat({(BW/32){32'hC2}}, 1'b0, 1'b0, 1'b0);
    add_beat({{(BW-32){1'b0}}, 32'h9}, 1'b0, 1'b0, 1'b0);
    add_beat({(BW/32){32'hC4}}, 1'b0, 1'b1, 1'b0);
    issue_pkt();
    wait_drain("backpressure", 400);

    // header-only flagged packet
    rdy_mode = 0;
    add_beat({(BW/32){32'hDEAD_BEEF}}, 1'b1, 1'b1, 1'b1);
    issue_pkt();
    wait_drain("hdr_only", 200);

    // reset in BODY after two data beats
    add_beat({(BW/32){32'hE0}}, 1'b1, 1'b0, 1'b1);
    add_beat({(BW/32){32'hE1}}, 1'b0, 1'b0, 1'b1);
    add_beat({(BW/32){32'hE2}}, 1'b0, 1'b0, 1'b1);
    add_beat({(BW/32){32'hE3}}, 1'b0, 1'b0, 1'b1);
    issue_pkt();
    begin
      int n = 0;
      do begin
        @(posedge clk);
        #3;
        n++;
      end while (fifo_q.size() != 1 && n < 100);
      check("reset_setup", EW'(fifo_q.size()), EW'(1));
    end
    check("pre_reset_valid", EW'(m_tvalid), EW'(1));
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {m_tlast, m_tuser, m_tdata}, '0);
    check("async_reset_valid", EW'(m_tvalid), '0);
    check("async_reset_state", EW'(dbg_state), EW'(IDLE));
    fifo_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) add_beat({(BW/32){32'hF0 + 32'(i)}}, (i == 0), (i == 2), 1'b0);
    issue_pkt();
    add_beat({(BW/32){32'hF8}}, 1'b0, 1'b0, 1'b1);
    add_beat({{(BW-32){1'b0}}, 32'h30}, 1'b0, 1'b1, 1'b1);
    issue_pkt();
    wait_drain("after_reset", 200);

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) rand_pkt();
    wait_drain("random", 5000);

    rdy_mode = 0;
    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
